// File: rtl/bram_init_writer_if.sv
// Purpose: write-side bus of bram_init_writer: user write request in, RAM write port out.
// Ports:   user_we/user_addr/user_din/user_ready (user path), ram_we/ram_addr/ram_din (RAM port).
// Modports: master = user/RAM side (the environment), slave = bram_init_writer.
interface bram_init_writer_if #(
   parameter int unsigned RAM_WIDTH  = 16,
   parameter int unsigned ADDR_WIDTH = 9
);
   logic                  user_we;
   logic [ADDR_WIDTH-1:0] user_addr;
   logic [RAM_WIDTH-1:0]  user_din;
   logic                  user_ready;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [RAM_WIDTH-1:0]  ram_din;

   modport master (
      output user_we, user_addr, user_din,
      input  user_ready, ram_we, ram_addr, ram_din
   );

   modport slave (
      input  user_we, user_addr, user_din,
      output user_ready, ram_we, ram_addr, ram_din
   );
endinterface

// File: rtl/bram_init_writer.sv
// Purpose: sweeps INIT_DEPTH words of INIT_VALUE from ADDR_OFFSET after reset or init_req,
//          then passes user writes straight to the RAM write port.
// Latency: one registered stage; a user write accepted in cycle N appears on ram_* after edge N+1.
// Backpressure: user_ready=0 while sweeping or on an init_req cycle; writes offered then are dropped.
// Ports: clk, rst (async, active-high), init_req (start/restart sweep), busy, done,
//        bus (slave): user_we/user_addr/user_din in, user_ready/ram_we/ram_addr/ram_din out.
module bram_init_writer #(
   parameter int unsigned          RAM_WIDTH   = 16,
   parameter int unsigned          ADDR_WIDTH  = 9,
   parameter int unsigned          INIT_DEPTH  = 16,
   parameter int unsigned          ADDR_OFFSET = 0,
   parameter logic [RAM_WIDTH-1:0] INIT_VALUE  = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_req,
   output logic              busy,
   output logic              done,
   bram_init_writer_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(INIT_DEPTH + 1);
   localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(INIT_DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(ADDR_OFFSET);

   generate
      if (INIT_DEPTH < 1) begin : g_bad_depth
         $error("bram_init_writer: INIT_DEPTH must be at least 1");
      end
      if ((64'(ADDR_OFFSET) + 64'(INIT_DEPTH)) > (64'(1) << ADDR_WIDTH)) begin : g_bad_range
         $error("bram_init_writer: sweep range exceeds the address space");
      end
   endgenerate

   typedef enum logic {ST_CLEAR, ST_DONE} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  ram_we_q, ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [RAM_WIDTH-1:0]  ram_din_q, ram_din_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [CNT_W-1:0]      cnt_eff;
   logic                  user_ready;

   assign user_ready     = (state_q == ST_DONE) && !init_req;
   assign bus.user_ready = user_ready;
   assign bus.ram_we     = ram_we_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_din    = ram_din_q;
   assign busy           = busy_q;
   assign done           = done_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ram_we_d   = ram_we_q;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      busy_d     = busy_q;
      done_d     = done_q;
      // A restart inside a sweep issues ADDR_OFFSET on the very edge it is seen.
      cnt_eff    = init_req ? '0 : cnt_q;

      case (state_q)
         ST_CLEAR: begin
            busy_d     = 1'b1;
            done_d     = 1'b0;
            ram_we_d   = 1'b1;
            ram_addr_d = ADDR_BASE + ADDR_WIDTH'(cnt_eff);
            ram_din_d  = INIT_VALUE;
            if (cnt_eff == LAST_CNT) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_eff + CNT_W'(1);
            end
         end
         default: begin
            if (init_req) begin
               state_d  = ST_CLEAR;
               cnt_d    = '0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               ram_we_d = 1'b0;
            end else begin
               // busy/done flip one edge after entering DONE, i.e. on the edge the
               // RAM samples the last clear write.
               busy_d   = 1'b0;
               done_d   = 1'b1;
               ram_we_d = bus.user_we;
               if (bus.user_we) begin
                  ram_addr_d = bus.user_addr;
                  ram_din_d  = bus.user_din;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_CLEAR;
         cnt_q      <= '0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         busy_q     <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_bram_init_writer.sv
// Bench for bram_init_writer: default instance (a), offset/fill instance (b), single-word instance (c).
module tb_bram_init_writer;

   typedef struct packed {
      logic [8:0]  addr;
      logic [15:0] din;
   } wr_t;

   logic clk;
   logic rst_a, rst_bc;
   logic init_a, init_b, init_c;
   logic busy_a, busy_b, busy_c;
   logic done_a, done_b, done_c;
   logic hold_b;

   int total = 0;
   int bad   = 0;
   wr_t sb_a[$];
   wr_t sb_b[$];

   bram_init_writer_if #(.RAM_WIDTH(16), .ADDR_WIDTH(9)) if_a ();
   bram_init_writer_if #(.RAM_WIDTH(16), .ADDR_WIDTH(9)) if_b ();
   bram_init_writer_if #(.RAM_WIDTH(16), .ADDR_WIDTH(9)) if_c ();

   bram_init_writer dut_a (
      .clk(clk), .rst(rst_a), .init_req(init_a), .busy(busy_a), .done(done_a), .bus(if_a)
   );

   bram_init_writer #(
      .RAM_WIDTH(16), .ADDR_WIDTH(9), .INIT_DEPTH(16), .ADDR_OFFSET(256), .INIT_VALUE(16'hA5A5)
   ) dut_b (
      .clk(clk), .rst(rst_bc), .init_req(init_b), .busy(busy_b), .done(done_b), .bus(if_b)
   );

   bram_init_writer #(
      .RAM_WIDTH(16), .ADDR_WIDTH(9), .INIT_DEPTH(1), .ADDR_OFFSET(5), .INIT_VALUE(16'h0007)
   ) dut_c (
      .clk(clk), .rst(rst_bc), .init_req(init_c), .busy(busy_c), .done(done_c), .bus(if_c)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Resetable-BRAM hold flag: released when the last sweep address is written.
   always @(posedge clk or posedge rst_bc) begin
      if (rst_bc) hold_b <= 1'b1;
      else if (if_b.ram_we && if_b.ram_addr == 9'd271) hold_b <= 1'b0;
   end

   always @(negedge clk) begin
      if (!rst_a && if_a.ram_we) begin
         if (sb_a.size() == 0) begin
            chk("a_unexpected_we", 32'(if_a.ram_we), 32'd0);
         end else begin
            wr_t e;
            e = sb_a.pop_front();
            chk("a_wr_addr", 32'(if_a.ram_addr), 32'(e.addr));
            chk("a_wr_din", 32'(if_a.ram_din), 32'(e.din));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_bc && if_b.ram_we) begin
         if (sb_b.size() == 0) begin
            chk("b_unexpected_we", 32'(if_b.ram_we), 32'd0);
         end else begin
            wr_t e;
            e = sb_b.pop_front();
            chk("b_wr_addr", 32'(if_b.ram_addr), 32'(e.addr));
            chk("b_wr_din", 32'(if_b.ram_din), 32'(e.din));
         end
      end
   end

   task automatic push_sweep_a(input int n);
      for (int i = 0; i < n; i++) sb_a.push_back('{addr: 9'(i), din: 16'h0000});
   endtask

   initial begin
      logic pd;
      rst_a = 1'b1; rst_bc = 1'b1;
      init_a = 1'b0; init_b = 1'b0; init_c = 1'b0;
      if_a.user_we = 1'b0; if_a.user_addr = '0; if_a.user_din = '0;
      if_b.user_we = 1'b0; if_b.user_addr = '0; if_b.user_din = '0;
      if_c.user_we = 1'b0; if_c.user_addr = '0; if_c.user_din = '0;

      // Reset state
      step(); step();
      chk("rst_we", 32'(if_a.ram_we), 0);
      chk("rst_addr", 32'(if_a.ram_addr), 0);
      chk("rst_din", 32'(if_a.ram_din), 0);
      chk("rst_busy", 32'(busy_a), 1);
      chk("rst_done", 32'(done_a), 0);
      chk("rst_ready", 32'(if_a.user_ready), 0);

      // Automatic sweep; a user write offered at cnt=5 must be dropped
      push_sweep_a(16);
      rst_a = 1'b0;
      for (int e = 1; e <= 16; e++) begin
         step();
         chk("swp_we", 32'(if_a.ram_we), 1);
         chk("swp_busy", 32'(busy_a), 1);
         if (e == 5) begin
            if_a.user_we = 1'b1; if_a.user_addr = 9'h1FF; if_a.user_din = 16'hBEEF;
         end
         if (e == 6) if_a.user_we = 1'b0;
      end
      step();
      chk("end_we", 32'(if_a.ram_we), 0);
      chk("end_busy", 32'(busy_a), 0);
      chk("end_done", 32'(done_a), 1);
      chk("end_ready", 32'(if_a.user_ready), 1);
      chk("end_sb", 32'(sb_a.size()), 0);

      // Pass-through user write, one cycle latency, then hold
      if_a.user_we = 1'b1; if_a.user_addr = 9'h12; if_a.user_din = 16'h1234;
      sb_a.push_back('{addr: 9'h12, din: 16'h1234});
      step();
      chk("usr_we", 32'(if_a.ram_we), 1);
      chk("usr_addr", 32'(if_a.ram_addr), 32'h12);
      chk("usr_din", 32'(if_a.ram_din), 32'h1234);
      if_a.user_we = 1'b0;
      step();
      chk("usr_we_off", 32'(if_a.ram_we), 0);
      chk("usr_addr_hold", 32'(if_a.ram_addr), 32'h12);

      // init_req together with user_we in DONE: write dropped, sweep restarts
      if_a.user_we = 1'b1; if_a.user_addr = 9'h33; if_a.user_din = 16'h5555;
      init_a = 1'b1;
      #1;
      chk("req_ready", 32'(if_a.user_ready), 0);
      step();
      chk("req_we", 32'(if_a.ram_we), 0);
      chk("req_busy", 32'(busy_a), 1);
      chk("req_done", 32'(done_a), 0);
      init_a = 1'b0; if_a.user_we = 1'b0;
      push_sweep_a(7);
      for (int e = 1; e <= 7; e++) step();
      // Restart at cnt=7
      init_a = 1'b1;
      push_sweep_a(16);
      step();
      chk("rs_we", 32'(if_a.ram_we), 1);
      chk("rs_addr", 32'(if_a.ram_addr), 0);
      init_a = 1'b0;
      for (int e = 1; e <= 15; e++) step();
      chk("rs_last_addr", 32'(if_a.ram_addr), 15);
      chk("rs_last_busy", 32'(busy_a), 1);
      step();
      chk("rs_done", 32'(done_a), 1);
      chk("rs_we_off", 32'(if_a.ram_we), 0);
      chk("rs_sb", 32'(sb_a.size()), 0);

      // Asynchronous reset mid-sweep at cnt=10
      init_a = 1'b1;
      step();
      init_a = 1'b0;
      chk("ar_start_we", 32'(if_a.ram_we), 0);
      push_sweep_a(9);
      for (int e = 1; e <= 10; e++) step();
      chk("ar_pre_addr", 32'(if_a.ram_addr), 9);
      #1 rst_a = 1'b1;
      #1;
      chk("ar_we", 32'(if_a.ram_we), 0);
      chk("ar_addr", 32'(if_a.ram_addr), 0);
      chk("ar_din", 32'(if_a.ram_din), 0);
      chk("ar_busy", 32'(busy_a), 1);
      chk("ar_done", 32'(done_a), 0);
      step(); step();
      push_sweep_a(16);
      rst_a = 1'b0;
      for (int e = 1; e <= 16; e++) step();
      step();
      chk("ar_full_done", 32'(done_a), 1);
      chk("ar_sb", 32'(sb_a.size()), 0);

      // Offset/fill instance and single-word instance
      for (int i = 0; i < 16; i++) sb_b.push_back('{addr: 9'(256 + i), din: 16'hA5A5});
      rst_bc = 1'b0;
      step();
      chk("c_we", 32'(if_c.ram_we), 1);
      chk("c_addr", 32'(if_c.ram_addr), 5);
      chk("c_din", 32'(if_c.ram_din), 7);
      chk("c_busy", 32'(busy_c), 1);
      step();
      chk("c_we_off", 32'(if_c.ram_we), 0);
      chk("c_done", 32'(done_c), 1);
      chk("c_busy_off", 32'(busy_c), 0);

      pd = done_b;
      for (int n = 0; n < 40; n++) begin
         pd = done_b;
         step();
         if (!hold_b) break;
      end
      chk("b_hold_clear", 32'(hold_b), 0);
      chk("b_done", 32'(done_b), 1);
      chk("b_done_prev", 32'(pd), 0);
      chk("b_sb", 32'(sb_b.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
